// File: rtl/cpu_pkg.sv
// cpu_pkg
//   Shared front-end definitions used by the fetch PC sequencer and the
//   modules around it.
//   Contents:
//     ADDR_W     instruction address width (also the return-stack entry width)
//     RAS_DEPTH  return-address stack depth
//     RESET_PC   fetch address loaded while reset is asserted
//     addr_t     instruction address type
//     pcseq_state_e  sequencer FSM state (RUN / RET_WAIT)
package cpu_pkg;

    localparam int ADDR_W    = 12;
    localparam int RAS_DEPTH = 8;

    typedef logic [ADDR_W-1:0] addr_t;

    localparam addr_t RESET_PC = '0;

    // RUN      : normal sequential / redirected fetch
    // RET_WAIT : one bubble cycle while the popped return address is applied
    typedef enum logic {
        RUN      = 1'b0,
        RET_WAIT = 1'b1
    } pcseq_state_e;

endpackage

// File: rtl/ras_occupancy_ctr.sv
// ras_occupancy_ctr
//   Saturating up/down counter tracking how many entries the return-address
//   stack holds. Increments on a push, decrements on a pop, sticks at 0 and at
//   DEPTH. A push into a full stack overwrites the oldest entry, so the count
//   stays at DEPTH.
//   Ports:
//     clk      in   clock, rising edge
//     rst_n    in   asynchronous active-low reset (count -> 0)
//     inc_i    in   push issued this cycle
//     dec_i    in   pop issued this cycle
//     count_o  out  current occupancy, $clog2(DEPTH)+1 bits
//     empty_o  out  occupancy == 0
//     full_o   out  occupancy == DEPTH
module ras_occupancy_ctr #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [CW-1:0] count_o,
    output logic          empty_o,
    output logic          full_o
);

    localparam logic [CW-1:0] FULL_VAL = CW'(DEPTH);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_VAL);
    assign count_o = count_q;

    // Push and pop are never issued together by the sequencer; if they were,
    // the count is left unchanged.
    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i && !full_o) begin
            count_d = count_q + ONE;
        end else if (dec_i && !inc_i && !empty_o) begin
            count_d = count_q - ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fetch_pc_sequencer.sv
// fetch_pc_sequencer
//   Front-end next-PC generator sitting directly upstream of the
//   return-address stack (RAS). Each cycle it selects the next fetch address
//   and issues single-cycle push (CALL) / pop (RET) pulses to the stack.
//   Next-PC priority in RUN: execute redirect > decoded RET > decoded CALL >
//   sequential pc+1. A RET pops the stack, inserts one bubble (RET_WAIT) and
//   then fetches from the captured top-of-stack value.
//
//   Optional feature, macro FETCH_RAS_GUARD_EN:
//     defined   -> stack occupancy is tracked; a RET on an empty stack does
//                  not pop and falls through to dec_pc+1; a CALL on a full
//                  stack still pushes and pulses ras_ovf. Adds ports ras_ovf
//                  and dbg_occ.
//     undefined -> every RET pops unconditionally; no counter, no ras_ovf.
//
//   Ports:
//     clk            in   clock, rising edge
//     rst_n          in   asynchronous active-low reset
//     stall          in   hold pc/pc_valid/state, suppress push/pop
//     ex_redirect    in   execute-stage redirect (always taken, even stalled)
//     ex_target      in   redirect target
//     dec_call       in   decoded CALL at dec_pc
//     dec_ret        in   decoded RET
//     dec_pc         in   address of the decoded instruction
//     dec_target     in   CALL target
//     ras_addr_in    in   stack top-of-stack, valid while ras_pop=1
//     pc             out  current fetch address (registered)
//     pc_valid       out  pc is a real fetch, 0 = bubble (registered)
//     ras_push       out  push pulse
//     ras_push_addr  out  return address dec_pc+1, 0 when no push
//     ras_pop        out  pop pulse
//     dbg_state      out  FSM state
//     ras_ovf        out  push into a full stack (guard build only)
//     dbg_occ        out  stack occupancy (guard build only)
//
//   Handshake: ras_push/ras_pop are combinational single-cycle commands with
//   no back-pressure; the stack accepts them on the rising edge that ends the
//   cycle. ras_addr_in is sampled on that same edge when ras_pop=1.
module fetch_pc_sequencer
    import cpu_pkg::*;
#(
    parameter int                ADDR_W    = cpu_pkg::ADDR_W,
    parameter int                RAS_DEPTH = cpu_pkg::RAS_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(cpu_pkg::RESET_PC)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        stall,
    input  logic                        ex_redirect,
    input  logic [ADDR_W-1:0]           ex_target,
    input  logic                        dec_call,
    input  logic                        dec_ret,
    input  logic [ADDR_W-1:0]           dec_pc,
    input  logic [ADDR_W-1:0]           dec_target,
    input  logic [ADDR_W-1:0]           ras_addr_in,
    output logic [ADDR_W-1:0]           pc,
    output logic                        pc_valid,
    output logic                        ras_push,
    output logic [ADDR_W-1:0]           ras_push_addr,
    output logic                        ras_pop,
`ifdef FETCH_RAS_GUARD_EN
    output logic                        ras_ovf,
    output logic [$clog2(RAS_DEPTH):0]  dbg_occ,
`endif
    output pcseq_state_e                dbg_state
);

    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    pcseq_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pc_valid_q, pc_valid_d;
    logic [ADDR_W-1:0] ret_tgt_q, ret_tgt_d;

    logic              take_dec;   // decode events may act this cycle
    logic              ret_ok;     // a decoded RET is allowed to pop
    logic              push_c;
    logic              pop_c;
    logic              ret_fall;   // RET on empty stack: fall through
    logic [ADDR_W-1:0] ret_addr;   // dec_pc + 1, wraps

    assign ret_addr = dec_pc + PC_ONE;

    // Decode events only count in RUN once the first post-reset fetch is out
    // (pc_valid_q=0 in RUN only happens right after reset), and only when
    // neither a stall nor a redirect overrides them.
    assign take_dec = (state_q == RUN) && pc_valid_q && !stall && !ex_redirect;

`ifdef FETCH_RAS_GUARD_EN
    logic ras_empty;
    logic ras_full;

    ras_occupancy_ctr #(
        .DEPTH (RAS_DEPTH)
    ) u_occ (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (push_c),
        .dec_i   (pop_c),
        .count_o (dbg_occ),
        .empty_o (ras_empty),
        .full_o  (ras_full)
    );

    assign ret_ok   = dec_ret && !ras_empty;
    assign ret_fall = take_dec && dec_ret && ras_empty;
    assign ras_ovf  = push_c && ras_full;
`else
    assign ret_ok   = dec_ret;
    assign ret_fall = 1'b0;
`endif

    // RET wins over a simultaneous CALL, so a CALL never pushes alongside a RET.
    assign pop_c  = take_dec && ret_ok;
    assign push_c = take_dec && dec_call && !dec_ret;

    assign ras_pop       = pop_c;
    assign ras_push      = push_c;
    assign ras_push_addr = push_c ? ret_addr : '0;

    assign pc        = pc_q;
    assign pc_valid  = pc_valid_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_valid_d = pc_valid_q;
        ret_tgt_d  = ret_tgt_q;

        if (ex_redirect) begin
            // A redirect is never lost: taken under stall and in RET_WAIT.
            // A pop already issued stays committed on the stack side.
            pc_d       = ex_target;
            pc_valid_d = 1'b1;
            state_d    = RUN;
        end else if (!stall) begin
            unique case (state_q)
                RUN: begin
                    if (!pc_valid_q) begin
                        // First cycle out of reset: fetch RESET_PC itself.
                        pc_valid_d = 1'b1;
                    end else if (pop_c) begin
                        ret_tgt_d  = ras_addr_in;
                        pc_valid_d = 1'b0;
                        state_d    = RET_WAIT;
                    end else if (ret_fall) begin
                        pc_d = ret_addr;
                    end else if (push_c) begin
                        pc_d = dec_target;
                    end else begin
                        pc_d = pc_q + PC_ONE;
                    end
                end
                RET_WAIT: begin
                    pc_d       = ret_tgt_q;
                    pc_valid_d = 1'b1;
                    state_d    = RUN;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            pc_valid_q <= 1'b0;
            ret_tgt_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            ret_tgt_q  <= ret_tgt_d;
        end
    end

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// tb_fetch_pc_sequencer
//   Directed scenarios with literal expectations, then randomized traffic.
//   A behavioural model (fetch address, bubble flag, return stack as a queue)
//   is compared against the DUT on every falling edge. Build with
//   +define+FETCH_RAS_GUARD_EN to exercise the occupancy guard.
module tb_fetch_pc_sequencer;
    import cpu_pkg::*;

    localparam int AW    = 12;
    localparam int DEPTH = 8;
`ifdef FETCH_RAS_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    // ---------------- clock / reset / DUT signals ----------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stall = 1'b0;
    logic          ex_redirect = 1'b0;
    logic [AW-1:0] ex_target = '0;
    logic          dec_call = 1'b0;
    logic          dec_ret = 1'b0;
    logic [AW-1:0] dec_pc = '0;
    logic [AW-1:0] dec_target = '0;
    logic [AW-1:0] ras_addr_in = '0;
    logic [AW-1:0] pc;
    logic          pc_valid;
    logic          ras_push;
    logic [AW-1:0] ras_push_addr;
    logic          ras_pop;
    pcseq_state_e  dbg_state;
`ifdef FETCH_RAS_GUARD_EN
    logic          ras_ovf;
    logic [3:0]    dbg_occ;
`endif

    always #5 clk = ~clk;

    fetch_pc_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .ex_redirect   (ex_redirect),
        .ex_target     (ex_target),
        .dec_call      (dec_call),
        .dec_ret       (dec_ret),
        .dec_pc        (dec_pc),
        .dec_target    (dec_target),
        .ras_addr_in   (ras_addr_in),
        .pc            (pc),
        .pc_valid      (pc_valid),
        .ras_push      (ras_push),
        .ras_push_addr (ras_push_addr),
        .ras_pop       (ras_pop),
`ifdef FETCH_RAS_GUARD_EN
        .ras_ovf       (ras_ovf),
        .dbg_occ       (dbg_occ),
`endif
        .dbg_state     (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [AW-1:0] m_pc = '0;
    bit            m_valid = 1'b0;
    bit            m_wait = 1'b0;      // bubble pending, return target in m_tgt
    logic [AW-1:0] m_tgt = '0;
    int            m_occ = 0;
    logic [AW-1:0] stk[$];             // expected return-stack contents

    bit            e_act, e_pop, e_push, e_ovf;
    logic [AW-1:0] e_addr;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_pc = '0; m_valid = 1'b0; m_wait = 1'b0; m_occ = 0;
            stk.delete();
            check("rst_pc", pc, 0);
            check("rst_valid", pc_valid, 0);
            check("rst_push", ras_push, 0);
            check("rst_pop", ras_pop, 0);
        end else begin
            e_act  = !m_wait && m_valid && !stall && !ex_redirect;
            e_pop  = e_act && dec_ret && (!GUARD || m_occ > 0);
            e_push = e_act && dec_call && !dec_ret;
            e_addr = e_push ? dec_pc + 12'd1 : 12'd0;
            e_ovf  = e_push && (m_occ == DEPTH);

            check("pc", pc, m_pc);
            check("pc_valid", pc_valid, m_valid);
            check("push", ras_push, e_push);
            check("push_addr", ras_push_addr, e_addr);
            check("pop", ras_pop, e_pop);
            check("state_ret_wait", dbg_state == RET_WAIT, m_wait);
`ifdef FETCH_RAS_GUARD_EN
            check("ovf", ras_ovf, e_ovf);
            check("occ", dbg_occ, m_occ);
`endif
            // what the next fetch address must be
            if (ex_redirect) begin
                m_pc = ex_target; m_valid = 1'b1; m_wait = 1'b0;
            end else if (!stall) begin
                if (m_wait) begin
                    m_pc = m_tgt; m_valid = 1'b1; m_wait = 1'b0;
                end else if (!m_valid) begin
                    m_valid = 1'b1;
                end else if (dec_ret) begin
                    if (e_pop) begin
                        m_tgt = ras_addr_in; m_valid = 1'b0; m_wait = 1'b1;
                    end else begin
                        m_pc = dec_pc + 12'd1;
                    end
                end else if (dec_call) begin
                    m_pc = dec_target;
                end else begin
                    m_pc = m_pc + 12'd1;
                end
            end
            if (e_push) begin
                stk.push_back(e_addr);
                if (stk.size() > DEPTH) void'(stk.pop_front());
                if (m_occ < DEPTH) m_occ++;
            end
            if (e_pop) begin
                if (stk.size() > 0) void'(stk.pop_back());
                if (m_occ > 0) m_occ--;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 1'b0; ex_redirect = 1'b0; dec_call = 1'b0; dec_ret = 1'b0;
    endtask

    task automatic rand_cycle();
        stall       = ($urandom_range(0, 4) == 0);
        ex_redirect = ($urandom_range(0, 9) == 0);
        ex_target   = ($urandom_range(0, 3) == 0) ? 12'hFFE + 12'($urandom_range(0, 1))
                                                  : 12'($urandom);
        dec_call    = ($urandom_range(0, 4) == 0);
        dec_ret     = ($urandom_range(0, 5) == 0);
        dec_pc      = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom);
        dec_target  = 12'($urandom);
        ras_addr_in = (stk.size() > 0) ? stk[$] : 12'($urandom);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle();
        repeat (2) step();
        check("init_pc", pc, 0);
        check("init_valid", pc_valid, 0);
        rst_n = 1'b1;
        step(); check("rel_pc0", pc, 12'h000); check("rel_valid0", pc_valid, 1);
        step(); check("rel_pc1", pc, 12'h001);
        step(); check("rel_pc2", pc, 12'h002);

        // async reset asserted mid-cycle takes effect immediately
        repeat (3) step();
        #2 rst_n = 1'b0;
        #1 check("async_rst_pc", pc, 12'h000);
        check("async_rst_valid", pc_valid, 0);
        step(); rst_n = 1'b1;
        step(); check("rel2_pc0", pc, 12'h000); check("rel2_valid", pc_valid, 1);
        step(); check("rel2_pc1", pc, 12'h001);

        // CALL then RET
        dec_call = 1'b1; dec_pc = 12'h010; dec_target = 12'h200;
        #1 check("call_push", ras_push, 1);
        check("call_addr", ras_push_addr, 12'h011);
        check("call_nopop", ras_pop, 0);
        step(); dec_call = 1'b0;
        check("call_pc", pc, 12'h200);
        step();
        dec_ret = 1'b1; ras_addr_in = 12'h011;
        #1 check("ret_pop", ras_pop, 1);
        check("ret_nopush", ras_push, 0);
        step(); dec_ret = 1'b0;
        check("ret_bubble", pc_valid, 0);
        step(); check("ret_pc", pc, 12'h011); check("ret_valid", pc_valid, 1);

        // redirect squashes a same-cycle CALL
        ex_redirect = 1'b1; ex_target = 12'h300;
        dec_call = 1'b1; dec_pc = 12'h123; dec_target = 12'h456;
        #1 check("redir_nopush", ras_push, 0);
        step(); idle();
        check("redir_pc", pc, 12'h300);

        // CALL so the stack holds an entry for the stalled RET
        dec_call = 1'b1; dec_pc = 12'h300; dec_target = 12'h400;
        step(); dec_call = 1'b0;
        check("call2_pc", pc, 12'h400);

        // stalled RET: nothing issued until the stall drops
        stall = 1'b1; dec_ret = 1'b1; ras_addr_in = 12'h301;
        for (int i = 0; i < 3; i++) begin
            #1 check("stall_nopop", ras_pop, 0);
            step(); check("stall_pc", pc, 12'h400);
        end
        stall = 1'b0;
        #1 check("unstall_pop", ras_pop, 1);
        step(); dec_ret = 1'b0;
        #1 check("unstall_once", ras_pop, 0);
        check("unstall_bubble", pc_valid, 0);
        step(); check("unstall_pc", pc, 12'h301);

        // wrap-around
        ex_redirect = 1'b1; ex_target = 12'hFFF;
        step(); ex_redirect = 1'b0;
        check("wrap_pc_fff", pc, 12'hFFF);
        step(); check("wrap_pc_000", pc, 12'h000);
        dec_call = 1'b1; dec_pc = 12'hFFF; dec_target = 12'h010;
        #1 check("wrap_push_addr", ras_push_addr, 12'h000);
        check("wrap_push", ras_push, 1);
        step(); dec_call = 1'b0;
        check("wrap_call_pc", pc, 12'h010);

`ifdef FETCH_RAS_GUARD_EN
        rst_n = 1'b0; step(); rst_n = 1'b1; step();
        dec_ret = 1'b1; dec_pc = 12'h040;
        #1 check("guard_empty_nopop", ras_pop, 0);
        step(); dec_ret = 1'b0;
        check("guard_empty_pc", pc, 12'h041);
        check("guard_empty_valid", pc_valid, 1);
        for (int i = 0; i < 9; i++) begin
            dec_call = 1'b1; dec_pc = 12'h100 + 12'(i); dec_target = 12'h200;
            #1 check("guard_ovf", ras_ovf, (i == 8) ? 1 : 0);
            step();
        end
        dec_call = 1'b0;
`endif

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                idle(); rst_n = 1'b0;
                step(); rst_n = 1'b1;
            end
            rand_cycle();
            step();
        end
        idle();
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
